mem_ctrl: RTL

Memory controller between the instruction-fetch/i-cache stage and the byte-wide main RAM. It serves 64-byte line fills for instruction fetch and 1/2/4-byte loads and stores for the load/store buffer, one transfer at a time. Arbitration between the two requesters is fair, and loads can be aborted on rollback. It drives the external RAM/IO port and applies back-pressure on IO writes when the IO buffer is full.

---
 rtl/mem_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates i-cache line fills and load/store-buffer accesses onto
// a byte-wide RAM/IO port, one transfer at a time.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   rdy                global enable; low freezes every register, gates mem_wr
//   mem_din/mem_dout   RAM read byte / write byte
//   mem_a, mem_wr      RAM byte address, write strobe (1 = write)
//   io_buffer_full     IO sink full; IO-address writes stall while high
//   if_en/if_pc        line-fill request and 64-byte aligned line address
//   if_done/if_data    one-cycle completion pulse and the filled line
//   lsb_en/lsb_wr/lsb_len/lsb_addr/lsb_w_data   load/store request
//   lsb_done/lsb_r_data one-cycle completion pulse and zero-extended load data
//   rollback           aborts an in-progress load, blocks a new load in IDLE
module mem_ctrl #(
  parameter int          ADDR_W     = 32,
  parameter int          LINE_BYTES = 64,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    if_en,
  input  logic [ADDR_W-1:0]       if_pc,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [1:0]              lsb_len,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [31:0]             lsb_w_data,
  output logic                    lsb_done,
  output logic [31:0]             lsb_r_data,
  input  logic                    rollback
);

  localparam int CW = $clog2(LINE_BYTES + 2) + 1;  // holds 0..LINE_BYTES
  localparam int LB = $clog2(LINE_BYTES);          // byte index within a line

  typedef enum logic [2:0] {IDLE, IF_READ, LS_READ, LS_WRITE, DONE} state_t;

  state_t          state, state_nx;
  logic            last_lsb;   // 0: IF served last (reset), 1: LSB served last
  logic [CW-1:0]   cnt;        // edges since accept (reads) / byte index (writes)
  logic [CW-1:0]   xfer_n;     // bytes in the current transfer
  logic [CW-1:0]   lsb_n;
  logic [31:0]     wbuf, rbuf, rbuf_nx;
  logic [LB-1:0]   cap_idx;
  logic [1:0]      wr_idx;
  logic            ls_req, pick_if, pick_ls, stall, rd_fin, wr_fin;

  // A load raised together with rollback belongs to the flushed path.
  assign ls_req  = lsb_en & ~(rollback & ~lsb_wr);
  // On a tie, serve whoever was not served last.
  assign pick_if = if_en & (~ls_req | last_lsb);
  assign pick_ls = ls_req & ~pick_if;

  assign stall   = (state == LS_WRITE) & io_buffer_full & (mem_a[17:16] == IO_BASE_HI);

  // Read pipeline: address k issued at edge k, byte k captured at edge k+2,
  // so at each edge the byte being captured is cnt-1 and the last one is
  // captured when cnt reaches N.
  assign rd_fin  = (cnt == xfer_n);
  assign wr_fin  = (cnt == xfer_n - 1'b1);
  assign cap_idx = LB'(cnt - 1'b1);
  assign wr_idx  = cnt[1:0] + 2'd1;

  // Illegal length 3 is served as a word.
  always_comb begin
    lsb_n = CW'(4);
    case (lsb_len)
      2'd0:    lsb_n = CW'(1);
      2'd1:    lsb_n = CW'(2);
      default: lsb_n = CW'(4);
    endcase
  end

  // Load buffer including the byte arriving this cycle, so the final byte
  // lands in lsb_r_data on the same edge that raises lsb_done.
  always_comb begin
    rbuf_nx = rbuf;
    rbuf_nx[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
  end

  assign mem_wr = rdy & (state == LS_WRITE) & ~stall;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pick_if)      state_nx = IF_READ;
        else if (pick_ls) state_nx = lsb_wr ? LS_WRITE : LS_READ;
      end
      IF_READ:  if (rd_fin) state_nx = DONE;
      LS_READ: begin
        if (rollback)    state_nx = IDLE;
        else if (rd_fin) state_nx = DONE;
      end
      LS_WRITE: if (!stall && wr_fin) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (rdy) state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a      <= '0;
      mem_dout   <= '0;
      if_done    <= 1'b0;
      if_data    <= '0;
      lsb_done   <= 1'b0;
      lsb_r_data <= '0;
      last_lsb   <= 1'b0;
      cnt        <= '0;
      xfer_n     <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_if) begin
            mem_a    <= if_pc;
            cnt      <= '0;
            xfer_n   <= CW'(LINE_BYTES);
            last_lsb <= 1'b0;
          end else if (pick_ls) begin
            mem_a    <= lsb_addr;
            cnt      <= '0;
            xfer_n   <= lsb_n;
            last_lsb <= 1'b1;
            rbuf     <= '0;
            wbuf     <= lsb_w_data;
            mem_dout <= lsb_w_data[7:0];
          end
        end
        IF_READ, LS_READ: begin
          if (state == LS_READ && rollback) begin
            // Abort: lsb_r_data keeps its previous value.
            mem_a <= '0;
          end else begin
            if (cnt + 1'b1 < xfer_n) mem_a <= mem_a + 1'b1;
            if (cnt != '0) begin
              if (state == IF_READ) if_data[{cap_idx, 3'b000} +: 8] <= mem_din;
              else                  rbuf <= rbuf_nx;
            end
            if (rd_fin) begin
              mem_a <= '0;
              if (state == IF_READ) begin
                if_done <= 1'b1;
              end else begin
                lsb_done   <= 1'b1;
                lsb_r_data <= rbuf_nx;
              end
            end
            cnt <= cnt + 1'b1;
          end
        end
        LS_WRITE: begin
          // A stalled IO byte holds address, data and index and retries.
          if (!stall) begin
            if (wr_fin) begin
              lsb_done <= 1'b1;
              mem_a    <= '0;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_a    <= mem_a + 1'b1;
              mem_dout <= wbuf[{wr_idx, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
